load_store_unit: RTL and testbench

Sits directly upstream of the word-wide DataMemory and is the core's only path into it. Accepts RV32I load/store requests with byte addresses and funct3 size/sign codes. Drives the memory's word-indexed MemRead/MemWrite interface. Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for SB/SH, because the memory has no byte enables. Flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory with no byte enables.
// Loads use byte-lane extraction with sign or zero extension. Sub-word stores
// use read-modify-write. Misaligned accesses and illegal funct3 codes are
// rejected without touching memory.
module load_store_unit #(
  parameter int Width = 32,
  parameter int AddrW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [AddrW-1:0]   req_addr,
  input  logic [Width-1:0]   req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [Width-1:0]   resp_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [AddrW-3:0]   mem_addr,
  output logic [Width-1:0]   mem_wdata,
  input  logic [Width-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               store_q, store_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;            // byte offset within the word
  logic [15:0]        wdata_lo_q, wdata_lo_d;  // only SB/SH need the latched data
  logic [AddrW-3:0]   mem_addr_q, mem_addr_d;
  logic [Width-1:0]   mem_wdata_q, mem_wdata_d;
  logic [Width-1:0]   resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic               funct3_bad;
  logic               misaligned;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [Width-1:0]   load_ext;
  logic [Width-1:0]   merged;

  // Classify the incoming request: unsupported funct3 or misaligned address.
  always_comb begin
    if (req_store) begin
      funct3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      funct3_bad = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]);
    end
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction with extension for loads, lane merge for sub-word stores.
  always_comb begin
    byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{(Width-8){~funct3_q[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{(Width-16){~funct3_q[2] & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_lo_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_lo_q;
    end
  end

  // Next-state and next-register computation for the request sequencer.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wdata_lo_d   = wdata_lo_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d    = req_store;
          funct3_d   = req_funct3;
          off_d      = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          mem_addr_d = req_addr[AddrW-1:2];
          if (funct3_bad || misaligned) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
            // Full-word store needs no read of the old word.
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (store_q) begin
          mem_wdata_d = merged;
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_ext;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      wdata_lo_q   <= 16'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wdata_lo_q   <= wdata_lo_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus random requests checked
// against a word-array reference model of memory and RV32I load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int failures = 0;

  logic [2:0]  t_f3   [7] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [9:0]  t_addr [7] = '{10'h014, 10'h015, 10'h016, 10'h016, 10'h016, 10'h016, 10'h014};
  logic [31:0] t_exp  [7] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h000000FF,
                              32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
  logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  load_store_unit #(.Width(32), .AddrW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // DataMemory model: registered read, write on MemWrite, bench preload port.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_idx] <= pl_data;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_bad(input logic st, input logic [2:0] f3, input logic [9:0] a);
    int  sz;
    logic legal;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    sz = 1 << int'(f3[1:0]);
    return (int'(a) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'h000000FF;
    h = (w >> (8 * int'(off))) & 32'h0000FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    if (f3 == 3'd2) return wd;
    mask = (f3 == 3'd0) ? 32'h000000FF : 32'h0000FFFF;
    return (w & ~(mask << (8 * int'(off)))) | ((wd & mask) << (8 * int'(off)));
  endfunction

  // One complete request: drive, watch the memory interface, check response.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [9:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] rd_o);
    logic        bad;
    int          exp_lat, exp_nr, exp_nw, exp_fr, exp_fw;
    logic [31:0] old_w, exp_rd, exp_w, wobs, robs;
    int          lat, nr, nw, fr, fw;
    logic        eobs;
    logic [7:0]  maddr;
    old_w = ref_mem[a[9:2]];
    bad = ref_bad(st, f3, a);
    if (bad)             begin exp_lat = 1; exp_nr = 0; exp_nw = 0; exp_fr = 0; exp_fw = 0; end
    else if (!st)        begin exp_lat = 3; exp_nr = 1; exp_nw = 0; exp_fr = 1; exp_fw = 0; end
    else if (f3 == 3'd2) begin exp_lat = 2; exp_nr = 0; exp_nw = 1; exp_fr = 0; exp_fw = 1; end
    else                 begin exp_lat = 4; exp_nr = 1; exp_nw = 1; exp_fr = 1; exp_fw = 3; end
    exp_rd = (bad || st) ? 32'd0 : ref_load(old_w, f3, a[1:0]);
    exp_w  = ref_store(old_w, f3, a[1:0], wd);
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nr = 0; nw = 0; fr = 0; fw = 0; wobs = 0; robs = 0; eobs = 1'b0; maddr = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_read)  begin nr++; if (fr == 0) fr = k; maddr = mem_addr; end
      if (mem_write) begin nw++; fw = k; wobs = mem_wdata; maddr = mem_addr; end
      if (resp_valid) begin lat = k; eobs = resp_err; robs = resp_rdata; end
    end
    check({tag, ".lat"},   lat, exp_lat);
    check({tag, ".err"},   {31'd0, eobs}, {31'd0, bad});
    check({tag, ".rdata"}, robs, exp_rd);
    check({tag, ".nread"}, nr, exp_nr);
    check({tag, ".nwrite"}, nw, exp_nw);
    check({tag, ".rdcyc"}, fr, exp_fr);
    check({tag, ".wrcyc"}, fw, exp_fw);
    if (exp_nw > 0) check({tag, ".wdata"}, wobs, exp_w);
    if (exp_nr + exp_nw > 0) check({tag, ".maddr"}, {24'd0, maddr}, {24'd0, a[9:2]});
    @(negedge clk);
    check({tag, ".idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
    check({tag, ".hold"}, resp_rdata, exp_rd);
    if (st && !bad) ref_mem[a[9:2]] = exp_w;
    rd_o = robs;
  endtask

  initial begin
    logic [31:0] r, r1, r2;
    int          acc, nresp, c1, a2, rds, nw, nv;
    logic        st;
    logic [2:0]  f3;
    logic [9:0]  a;

    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 10'd0; req_wdata = 32'd0;
    pl_we = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h80FF7F01;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_idx = 8'(i); pl_data = ref_mem[i];
    end
    @(negedge clk);
    pl_we = 1'b0;

    // Reset state
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.ctl", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.maddr", {24'd0, mem_addr}, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer loads from word 5
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, t_f3[i], t_addr[i], 32'd0, $sformatf("kat%0d", i), r);
      check($sformatf("kat%0d.const", i), r, t_exp[i]);
    end

    // SB read-modify-write, then read back
    do_req(1'b1, 3'd0, 10'h015, 32'h123456AB, "sb", r);
    do_req(1'b0, 3'd2, 10'h014, 32'd0, "sb.lw", r);
    check("sb.lw.const", r, 32'h80FFAB01);

    // SW
    do_req(1'b1, 3'd2, 10'h020, 32'hDEADBEEF, "sw", r);

    // Error cases
    do_req(1'b1, 3'd1, 10'h013, 32'h0000FFFF, "err.sh", r);
    do_req(1'b0, 3'd2, 10'h016, 32'd0, "err.lw", r);
    do_req(1'b0, 3'd3, 10'h014, 32'd0, "err.f3", r);

    // Back-to-back LW with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 10'h014; req_wdata = 32'd0;
    acc = 0; nresp = 0; c1 = 0; a2 = 0; rds = 0; r1 = 0; r2 = 0;
    for (int c = 1; c <= 20 && nresp < 2; c++) begin
      if (req_valid && req_ready) begin acc++; if (acc == 2) a2 = c - 1; end
      @(posedge clk);
      #1;
      if (acc == 1) req_addr = 10'h020;
      if (acc == 2) req_valid = 1'b0;
      @(negedge clk);
      if (mem_read) rds++;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin c1 = c; r1 = resp_rdata; end
        else r2 = resp_rdata;
      end
    end
    req_valid = 1'b0;
    check("b2b.nresp", nresp, 32'd2);
    check("b2b.r1", r1, ref_mem[5]);
    check("b2b.r2", r2, ref_mem[8]);
    check("b2b.accept2", a2, c1 + 1);
    check("b2b.nread", rds, 32'd2);
    @(negedge clk);

    // Reset in CAPTURE of an SH
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1; req_addr = 10'h016; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rsh.read", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rsh.ready", {31'd0, req_ready}, 32'd1);
    check("rsh.ctl", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("rsh.rdata", resp_rdata, 32'd0);
    check("rsh.maddr", {24'd0, mem_addr}, 32'd0);
    check("rsh.wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nw = 0; nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_write) nw++;
      if (resp_valid) nv++;
    end
    check("rsh.nwrite", nw, 32'd0);
    check("rsh.nresp", nv, 32'd0);
    do_req(1'b0, 3'd2, 10'h014, 32'd0, "rsh.lw", r);
    check("rsh.lw.const", r, 32'h80FFAB01);

    // Random requests against the reference model
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      a  = 10'($urandom_range(0, 1023));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else    f3 = load_f3[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_req(st, f3, a, $urandom, $sformatf("rnd%0d", i), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
